seg_pattern_sequencer: RTL

Programmable step sequencer that drives the 7-segment fade/PWM engine. It stores up to `STEPS` 7-bit segment masks loaded one word at a time. In playback it steps through them at a selectable rate, presenting the current mask plus a one-cycle strobe so the fade engine can re-light those segments. It replaces the fixed hard-coded "snake" order with a loadable animation and sits between the input pins and the fade engine.

---
 rtl/seg_pattern_sequencer_if.sv | 32 +++
 rtl/seg_pattern_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seg_pattern_sequencer_if.sv
// Control/status bundle between the pin-side controller (master) and the
// pattern sequencer (slave).
interface seg_pattern_sequencer_if #(
  parameter int STEPS       = 8,
  parameter int SPEED_WIDTH = 3
);
  localparam int IDX_W = $clog2(STEPS);

  logic                   load_en;
  logic                   load_valid;
  logic [6:0]             load_data;
  logic                   run;
  logic                   dir;
  logic [SPEED_WIDTH-1:0] speed;

  logic [6:0]             seg_mask;
  logic                   step_strobe;
  logic [IDX_W-1:0]       step_idx;
  logic [IDX_W:0]         length;
  logic                   load_full;
  logic [1:0]             state;

  modport master (
    output load_en, load_valid, load_data, run, dir, speed,
    input  seg_mask, step_strobe, step_idx, length, load_full, state
  );

  modport slave (
    input  load_en, load_valid, load_data, run, dir, speed,
    output seg_mask, step_strobe, step_idx, length, load_full, state
  );
endinterface

// File: rtl/seg_pattern_sequencer.sv
// Loadable step sequencer feeding the 7-segment fade engine.
// Optional macro SEQ_BOUNCE_EN selects ping-pong playback instead of wrap-around.
module seg_pattern_sequencer #(
  parameter int STEPS          = 8,
  parameter int PRESCALE_WIDTH = 12,
  parameter int SPEED_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  seg_pattern_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(STEPS);
  localparam int LEN_W = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [IDX_W-1:0]          step_idx_q, step_idx_d;
  logic [6:0]                seg_mask_q, seg_mask_d;
  logic                      step_strobe_q, step_strobe_d;
  logic                      load_full_q, load_full_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [SPEED_WIDTH-1:0]    tick_q, tick_d;
  logic [6:0]                pat_mem_q [STEPS];

  logic                      wr_en;
  logic [IDX_W-1:0]          last_idx, entry_idx, nxt_idx;

  assign last_idx  = IDX_W'(len_q - 1'b1);
  assign entry_idx = bus.dir ? '0 : last_idx;

`ifdef SEQ_BOUNCE_EN
  logic dir_q, dir_d, nxt_dir;

  // Turn around at either end; a single-step table just repeats index 0.
  always_comb begin
    nxt_idx = step_idx_q;
    nxt_dir = dir_q;
    if (last_idx == '0) begin
      nxt_idx = '0;
    end else if (dir_q) begin
      if (step_idx_q == last_idx) begin
        nxt_idx = step_idx_q - 1'b1;
        nxt_dir = 1'b0;
      end else begin
        nxt_idx = step_idx_q + 1'b1;
      end
    end else begin
      if (step_idx_q == '0) begin
        nxt_idx = IDX_W'(1);
        nxt_dir = 1'b1;
      end else begin
        nxt_idx = step_idx_q - 1'b1;
      end
    end
  end
`else
  always_comb begin
    nxt_idx = step_idx_q;
    if (bus.dir) nxt_idx = (step_idx_q == last_idx) ? '0 : step_idx_q + 1'b1;
    else         nxt_idx = (step_idx_q == '0) ? last_idx : step_idx_q - 1'b1;
  end
`endif

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    step_idx_d    = step_idx_q;
    seg_mask_d    = seg_mask_q;
    step_strobe_d = 1'b0;
    presc_d       = presc_q;
    tick_d        = tick_q;
    wr_en         = 1'b0;
`ifdef SEQ_BOUNCE_EN
    dir_d         = dir_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.load_en) begin
          state_d = S_LOAD;
          len_d   = '0;
        end else if (bus.run && (len_q != '0)) begin
          state_d       = S_RUN;
          step_idx_d    = entry_idx;
          seg_mask_d    = pat_mem_q[entry_idx];
          step_strobe_d = 1'b1;
          presc_d       = '0;
          tick_d        = '0;
`ifdef SEQ_BOUNCE_EN
          dir_d         = bus.dir;
`endif
        end
      end

      S_LOAD: begin
        if (bus.load_valid && (len_q != LEN_W'(STEPS))) begin
          wr_en = 1'b1;
          len_d = len_q + 1'b1;
        end
        if (!bus.load_en) state_d = S_IDLE;
      end

      S_RUN: begin
        if (!bus.run) begin
          state_d    = S_IDLE;
          seg_mask_d = '0;
          presc_d    = '0;
          tick_d     = '0;
        end else begin
          presc_d = presc_q + 1'b1;
          // A base tick is the prescaler wrapping; the step fires on tick number speed+1.
          if (&presc_q) begin
            if (tick_q == bus.speed) begin
              tick_d        = '0;
              step_idx_d    = nxt_idx;
              seg_mask_d    = pat_mem_q[nxt_idx];
              step_strobe_d = 1'b1;
`ifdef SEQ_BOUNCE_EN
              dir_d         = nxt_dir;
`endif
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    load_full_d = (len_d == LEN_W'(STEPS));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      step_idx_q    <= '0;
      seg_mask_q    <= '0;
      step_strobe_q <= 1'b0;
      load_full_q   <= 1'b0;
      presc_q       <= '0;
      tick_q        <= '0;
`ifdef SEQ_BOUNCE_EN
      dir_q         <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      step_idx_q    <= step_idx_d;
      seg_mask_q    <= seg_mask_d;
      step_strobe_q <= step_strobe_d;
      load_full_q   <= load_full_d;
      presc_q       <= presc_d;
      tick_q        <= tick_d;
`ifdef SEQ_BOUNCE_EN
      dir_q         <= dir_d;
`endif
    end
  end

  // NOTE: the pattern table is deliberately not reset; length 0 hides stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) pat_mem_q[len_q[IDX_W-1:0]] <= bus.load_data;
  end

  assign bus.state       = state_q;
  assign bus.length      = len_q;
  assign bus.step_idx    = step_idx_q;
  assign bus.seg_mask    = seg_mask_q;
  assign bus.step_strobe = step_strobe_q;
  assign bus.load_full   = load_full_q;
endmodule
